addsub_seq: RTL



---
 rtl/addsub_seq.sv | 119 +++++++++++
 1 files changed

// File: rtl/addsub_seq.sv
// Sequential add/subtract unit: a WIDTH-bit operation is processed CHUNK bits per
// clock with a registered carry rippling between slices; start/busy/done handshake.
module addsub_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic [1:0]       dbg_state
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Handshake: a request is taken on any rising edge where start=1 and the unit
    // is not in RUN (IDLE or DONE); done is a one-cycle pulse with result/flags
    // valid, and they then hold until the next accepted request.
    state_t            state;
    state_t            state_next;
    logic              accept;
    logic              last;

    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic              carry;
    logic [IDXW-1:0]   idx;

    int                base;
    logic [CHUNK-1:0]  slice_a;
    logic [CHUNK-1:0]  slice_b;
    logic [CHUNK:0]    slice_sum;
    logic              msb_cin;
    logic [WIDTH-1:0]  res_next;

    assign accept    = start && (state != S_RUN);
    assign last      = (idx == IDXW'(NCHUNK - 1));
    assign busy      = (state == S_RUN);
    assign done      = (state == S_DONE);
    assign dbg_state = state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (last)  state_next = S_DONE;
            S_DONE:  state_next = start ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // One slice of the adder, selected by the slice index.
    always_comb begin
        base      = int'(idx) * CHUNK;
        slice_a   = op_a[base +: CHUNK];
        slice_b   = op_b[base +: CHUNK];
        slice_sum = {1'b0, slice_a} + {1'b0, slice_b} + {{CHUNK{1'b0}}, carry};
        // Carry into the slice MSB recovered from its sum bit; on the last slice
        // this is the carry into bit WIDTH-1.
        msb_cin   = slice_a[CHUNK-1] ^ slice_b[CHUNK-1] ^ slice_sum[CHUNK-1];
        res_next  = result;
        res_next[base +: CHUNK] = slice_sum[CHUNK-1:0];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_a     <= '0;
            op_b     <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (accept) begin
            // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
            op_a  <= a;
            op_b  <= b ^ {WIDTH{sub}};
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
        end else if (state == S_RUN) begin
            result <= res_next;
            carry  <= slice_sum[CHUNK];
            if (last) begin
                idx      <= '0;
                cout     <= slice_sum[CHUNK];
                overflow <= msb_cin ^ slice_sum[CHUNK];
                zero     <= (res_next == '0);
            end else begin
                idx <= idx + IDXW'(1);
            end
        end
    end

endmodule
